alu_mult_seq: RTL
=================

# alu_mult_seq

Multi-cycle 8x8 unsigned shift-and-add multiplier sequencer that sits directly in front of the `alu` and consumes its outputs. It drives `A`, `B` and `FunSel` of the ALU, samples `OutALU` and the carry bit of `ZCNO`, and performs the shifts internally. It returns a 16-bit product with a START/BUSY/DONE handshake. The ALU itself performs every addition, so the ALU's adder and carry path are exercised by real workloads.

## Interface
- `FS_ADD`, default 4'h4: ALU FunSel code for A+B with carry-out.
- `FS_IDLE`, default 4'h0: FunSel driven when no add is requested.
- `CBIT`, default 2: index of the carry flag within `ZCNO` (bit order Z,C,N,O, MSB first).
- `CLK` input 1: single clock; all state updates on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `START` input 1: request a multiply; sampled only when idle.
- `MCAND` input 8: multiplicand; captured when START is accepted.
- `MPLIER` input 8: multiplier; captured when START is accepted.
- `BUSY` output 1: high while a multiply is in progress.
- `DONE` output 1: one-cycle pulse when PRODUCT is updated.
- `PRODUCT` output 16: last result; holds until the next completion.
- `ALU_A` output 8: to ALU A. Equals the running high byte P while busy, else 0.
- `ALU_B` output 8: to ALU B. Equals the captured multiplicand M while busy, else 0.
- `ALU_FUNSEL` output 4: to ALU FunSel.
- `ALU_OUT` input 8: from ALU OutALU.
- `ALU_ZCNO` input 4: from ALU ZCNO.

## Operation
- Internal registers:
  - M[7:0]: multiplicand.
  - P[7:0]: high partial product.
  - Q[7:0]: multiplier / low partial product.
  - CNT[2:0]: iteration counter.
  - STATE: one of IDLE, ITER, CAPT.
- IDLE:
  - START=1 at an edge loads M=MCAND, Q=MPLIER, P=0, CNT=0, and moves to ITER.
  - Otherwise the block stays in IDLE.
- ITER, Q[0]=0:
  - {P,Q} <= {1'b0,P,Q} >> 1 and CNT <= CNT+1.
  - If CNT was 7, finish; else stay in ITER.
- ITER, Q[0]=1:
  - ALU_FUNSEL=FS_ADD, combinational from state and Q[0].
  - Move to CAPT with no register change.
- CAPT:
  - ALU_FUNSEL stays FS_ADD and ALU_A/ALU_B are held.
  - At the edge: {P,Q} <= {ALU_ZCNO[CBIT], ALU_OUT, Q} >> 1 and CNT <= CNT+1.
  - If CNT was 7, finish; else go to ITER.
- Finish, at the same edge:
  - PRODUCT <= next {P,Q}, DONE <= 1, and STATE <= IDLE.
- ALU_FUNSEL=FS_IDLE in every cycle other than ITER with Q[0]=1, and CAPT.
- Arithmetic is unsigned. The carry is the 9th sum bit and is shifted into P[7]. No overflow can occur because the product fits in 16 bits.
- The block does not use ALU flags other than carry.
- START while BUSY is ignored, with no queueing. MCAND/MPLIER changes while BUSY have no effect.
- Operands of 0 are legal. M=0 still issues adds when Q bits are 1, and the result is 0.

## Timing
- Reset values:
  - BUSY=0, DONE=0, PRODUCT=16'h0000.
  - ALU_A=0, ALU_B=0, ALU_FUNSEL=FS_IDLE.
  - STATE=IDLE; M, P, Q, CNT = 0.
- RST_N low mid-operation aborts immediately and asynchronously to the reset values. No DONE is issued.
- START accepted at edge k: BUSY=1 from edge k.
- Latency: DONE=1 for exactly the cycle following edge k+8+popcount(MPLIER), with BUSY=0 in that same cycle.
  - Each 0 bit costs 1 cycle; each 1 bit costs 2 cycles (ITER+CAPT).
  - Range is 8 to 16 cycles.
- Back-to-back: START high during the DONE cycle is accepted at the next edge. DONE then falls and BUSY rises together.
- ALU inputs are stable for the whole ITER(Q[0]=1)+CAPT pair, so the sample is correct whether ALU flags are combinational or registered on CLK.
- CNT wraps 7→0 only at finish.

## Test plan
- MCAND=8'h05, MPLIER=8'h02, START at edge k -> DONE pulse after edge k+9, PRODUCT=16'h000A. ALU_FUNSEL=FS_ADD for exactly 2 cycles.
- MCAND=8'hFF, MPLIER=8'hFF -> PRODUCT=16'hFE01, latency 16 cycles, carry captured on every add after the first.
- MCAND=8'h7F, MPLIER=8'h00 -> PRODUCT=16'h0000, latency 8, ALU_FUNSEL never leaves FS_IDLE.
- Run 8'h80×8'h80, then assert START with 8'h03×8'h07 during the DONE cycle -> PRODUCT 16'h4000, then 16'h0015. A second START pulsed mid-run is ignored.
- Start 8'hAA×8'h55, drop RST_N 5 cycles later -> all outputs go to reset values at once with no DONE. After release, 8'h02×8'h03 gives 16'h0006.
- Random sweep of 500 operand pairs against a behavioural ALU model or the real `alu` -> PRODUCT == MCAND×MPLIER and latency == 8+popcount(MPLIER) for every pair.

Source files
------------

// File: rtl/alu_mult_seq.sv
// 8x8 unsigned shift-and-add multiplier that sequences an external ALU for every add.
// The carry-out of each ALU add becomes the bit shifted into the top of the high byte P.
module alu_mult_seq #(
   parameter logic [3:0] FS_ADD  = 4'h4,
   parameter logic [3:0] FS_IDLE = 4'h0,
   parameter int         CBIT    = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic [7:0]  MCAND,
   input  logic [7:0]  MPLIER,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] PRODUCT,
   output logic [7:0]  ALU_A,
   output logic [7:0]  ALU_B,
   output logic [3:0]  ALU_FUNSEL,
   input  logic [7:0]  ALU_OUT,
   input  logic [3:0]  ALU_ZCNO
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_CAPT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  m_q, m_d;
   logic [7:0]  p_q, p_d;
   logic [7:0]  q_q, q_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] prod_q, prod_d;
   logic        done_q, done_d;
   logic [15:0] pq_nxt;
   logic        fin;
   logic        unused_zcno;

   // Only the carry flag is consumed; the other flag bits are intentionally ignored.
   assign unused_zcno = ^ALU_ZCNO;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         p_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      p_d     = p_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      fin     = 1'b0;
      pq_nxt  = {p_q, q_q};
      case (state_q)
         S_IDLE: begin
            if (START) begin
               m_d     = MCAND;
               q_d     = MPLIER;
               p_d     = '0;
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            // A set LSB defers the shift to CAPT so the ALU sum has a full cycle to settle.
            if (!q_q[0]) begin
               pq_nxt = {1'b0, p_q, q_q[7:1]};
               {p_d, q_d} = pq_nxt;
               cnt_d = cnt_q + 3'd1;
               fin   = (cnt_q == 3'd7);
            end else begin
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            pq_nxt = {ALU_ZCNO[CBIT], ALU_OUT, q_q[7:1]};
            {p_d, q_d} = pq_nxt;
            cnt_d   = cnt_q + 3'd1;
            fin     = (cnt_q == 3'd7);
            state_d = S_ITER;
         end
         default: state_d = S_IDLE;
      endcase
      if (fin) begin
         prod_d  = pq_nxt;
         done_d  = 1'b1;
         state_d = S_IDLE;
      end
   end

   assign BUSY       = (state_q != S_IDLE);
   assign DONE       = done_q;
   assign PRODUCT    = prod_q;
   assign ALU_A      = BUSY ? p_q : 8'h00;
   assign ALU_B      = BUSY ? m_q : 8'h00;
   assign ALU_FUNSEL = ((state_q == S_ITER && q_q[0]) || state_q == S_CAPT) ? FS_ADD : FS_IDLE;

endmodule
